// File: rtl/mccoy_core_p_if.sv
// Instruction/result bundle for the mccoy_core_p accumulator core.
// The master drives instructions; the slave (the core) returns results and status.
interface mccoy_core_p_if #(
  parameter int DATA_W = 8
);
  logic [5:0]        instr;
  logic              instr_valid;
  logic              instr_ready;
  logic [DATA_W-1:0] data_out;
  logic              out_valid;
  logic              carry;
  logic              busy;

  modport master (
    output instr, instr_valid,
    input  instr_ready, data_out, out_valid, carry, busy
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, data_out, out_valid, carry, busy
  );
endinterface

// File: rtl/mccoy_core_p.sv
// Accumulator core fed by an instruction FIFO.
// MUL runs as a multi-cycle shift-add multiply.
module mccoy_core_p #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  mccoy_core_p_if.slave bus
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int MCW   = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {ST_EXEC, ST_MUL} state_t;

  state_t state, next_state;

  logic [5:0]          fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr, rd_ptr;
  logic [CNT_W-1:0]    count;
  logic                full, empty, push, pop, ready_int;
  logic [5:0]          head;
  logic [1:0]          opc, oo, rr;
  logic [3:0]          imm;

  logic [DATA_W-1:0]   acc, data_out_q, rval;
  logic [DATA_W-1:0]   regs [4];
  logic                carry_q, out_valid_q, busy_int;
  logic [DATA_W:0]     add_res;

  logic [2*DATA_W-1:0] mul_prod, mul_mcand, mul_partial;
  logic [DATA_W-1:0]   mul_mplier;
  logic [MCW-1:0]      mul_cnt;
  logic                mul_last, head_is_mul;

  assign full      = (count == CNT_W'(FIFO_DEPTH));
  assign empty     = (count == '0);
  assign ready_int = !reset && !full;
  assign push      = bus.instr_valid && ready_int;
  assign pop       = (state == ST_EXEC) && !empty;

  assign head = fifo_mem[rd_ptr];
  assign opc  = head[5:4];
  assign oo   = head[3:2];
  assign rr   = head[1:0];
  assign imm  = head[3:0];
  assign rval = regs[rr];

  assign add_res     = {1'b0, acc} + {1'b0, rval};
  assign head_is_mul = (head[5:2] == 4'b1101);
  assign mul_partial = mul_prod + (mul_mplier[0] ? mul_mcand : '0);
  assign mul_last    = (mul_cnt == MCW'(DATA_W - 1));

  assign bus.instr_ready = ready_int;
  assign bus.data_out    = data_out_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.carry       = carry_q;
  assign bus.busy        = busy_int;

  // Storage only; validity is tracked by the pointers and count below.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= bus.instr;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= (wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= (rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_EXEC;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_EXEC: if (pop && head_is_mul) next_state = ST_MUL;
      ST_MUL:  if (mul_last)           next_state = ST_EXEC;
      default: next_state = ST_EXEC;
    endcase
  end

  always_comb begin
    busy_int = 1'b0;
    if (state == ST_MUL) busy_int = 1'b1;
  end

  // The final shift-add step writes its partial sum straight into ACC and carry.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc         <= '0;
      carry_q     <= 1'b0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
      mul_prod    <= '0;
      mul_mcand   <= '0;
      mul_mplier  <= '0;
      mul_cnt     <= '0;
      for (int i = 0; i < 4; i++) regs[i] <= '0;
    end else begin
      out_valid_q <= 1'b0;
      if (state == ST_MUL) begin
        mul_prod   <= mul_partial;
        mul_mcand  <= mul_mcand << 1;
        mul_mplier <= mul_mplier >> 1;
        mul_cnt    <= mul_cnt + MCW'(1);
        if (mul_last) begin
          acc     <= mul_partial[DATA_W-1:0];
          carry_q <= |mul_partial[2*DATA_W-1:DATA_W];
        end
      end else if (pop) begin
        case (opc)
          2'b00: acc <= DATA_W'(imm);
          2'b01: begin
            case (oo)
              2'b00: begin
                acc     <= add_res[DATA_W-1:0];
                carry_q <= add_res[DATA_W];
              end
              2'b01: begin
                acc     <= acc - rval;
                carry_q <= (acc < rval);
              end
              2'b10: begin
                acc     <= acc & rval;
                carry_q <= 1'b0;
              end
              default: begin
                acc     <= acc ^ rval;
                carry_q <= 1'b0;
              end
            endcase
          end
          2'b10: begin
            case (oo)
              2'b00: regs[rr] <= acc;
              2'b01: acc <= rval;
              2'b10: begin
                acc     <= {acc[DATA_W-2:0], 1'b0};
                carry_q <= acc[DATA_W-1];
              end
              default: begin
                acc     <= {1'b0, acc[DATA_W-1:1]};
                carry_q <= acc[0];
              end
            endcase
          end
          default: begin
            case (oo)
              2'b00: begin
                data_out_q  <= acc;
                out_valid_q <= 1'b1;
              end
              2'b01: begin
                mul_prod   <= '0;
                mul_mcand  <= {{DATA_W{1'b0}}, acc};
                mul_mplier <= rval;
                mul_cnt    <= '0;
              end
              2'b10: ;
              default: begin
                acc     <= '0;
                carry_q <= 1'b0;
              end
            endcase
          end
        endcase
      end
    end
  end

endmodule
